alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default `XLEN, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; a transfer on port i occurs when req_valid[i] and req_ready[i] are both high at the clock edge.
REQ-006 req_a0, req_b0 / req_a1, req_b1  input  N each  operands for requester 0 / 1.
REQ-007 req_op0 / req_op1  input  4 each  ALU op code for requester 0 / 1, using the team ALU encoding (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_EQ, ALU_NE, ALU_SLT, ALU_SLTU, ALU_SGE, ALU_SGEU).
REQ-008 rsp_valid  output  1  response buffer holds a result.
REQ-009 rsp_ready  input  1  consumer accepts the response.
REQ-010 rsp_id  output  1  requester index that owns the response.
REQ-011 rsp_result  output  N  registered ALU result.
REQ-012 rsp_illegal  output  1  op code of the response was outside the defined set.

Function
REQ-013 Block SHALL contain exactly one ALU datapath, shared by both requesters.
REQ-014 One-entry response buffer: can_accept = !rsp_valid | rsp_ready (combinational from rsp_ready).
REQ-015 Grant is one-hot or zero; req_ready[i] = grant[i] & can_accept; req_ready SHALL NOT depend on req_op or operands.
REQ-016 Only one requester is valid: that requester is granted.
REQ-017 Both valid: winner per arbitration policy (REQ-029/030).
REQ-018 Latency: a request accepted at edge k SHALL present rsp_valid=1 with result, id and illegal flag immediately after edge k.
REQ-019 Result SHALL equal the ALU function of the accepted operands: ADD/SUB modulo 2^N; AND/OR/XOR bitwise; compare ops return zero-extended 1-bit result (EQ, NE, signed LT/GE, unsigned LTU/GEU).
REQ-020 Undefined op code: rsp_result = 0, rsp_illegal = 1; otherwise rsp_illegal = 0; never X.
REQ-021 While rsp_valid & !rsp_ready, rsp_result, rsp_id and rsp_illegal SHALL hold stable and req_ready SHALL be 0.
REQ-022 rsp_valid & rsp_ready with a new accept in the same cycle: buffer reloads with no bubble (one result per cycle sustained).
REQ-023 rsp_valid & rsp_ready with no accept: rsp_valid falls after the edge.
REQ-024 A requester that drops req_valid without a transfer is not served and leaves no state.
REQ-025 Arbitration state SHALL update only on an actual transfer.

Reset
REQ-026 rst_n low SHALL asynchronously force rsp_valid=0, rsp_id=0, rsp_result=0, rsp_illegal=0, and priority pointer=requester 0.
REQ-027 Reset asserted with a response pending: response discarded, never re-presented.
REQ-028 Reset deassertion: first accept possible on the first rising edge with rst_n high.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: round-robin; pointer names the preferred requester; after a transfer on port i, pointer becomes 1-i.
REQ-030 Macro ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; no pointer register is implemented.

Verification
REQ-031 Reset, then req0 ADD a=5 b=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_illegal=0.
REQ-032 req1 SLT a=0xFFFFFFFF b=1 and, separately, SLTU with the same operands (N=32) -> results 1 and 0.
REQ-033 Both valid for 4 cycles, rsp_ready=1 -> with RR_EN ids 0,1,0,1; without RR_EN ids 0,0,0,0.
REQ-034 rsp_ready=0 for 3 cycles with response pending -> outputs stable, req_ready=00; rsp_ready=1 -> drain and reload on the same edge.
REQ-035 Op code 4'b1111 on req0 -> rsp_result=0, rsp_illegal=1.
REQ-036 rst_n pulsed low mid-cycle while rsp_valid=1 -> rsp_valid=0 immediately; after release next grant goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one ALU, one-entry response buffer
// Optional feature macro: ALU_ARB_RR_EN (round-robin); undefined gives fixed priority, requester 0 wins.
// ALU op encoding: ADD=0 SUB=1 AND=2 OR=3 XOR=4 EQ=5 NE=6 SLT=7 SLTU=8 SGE=9 SGEU=10, 11..15 illegal.

`ifndef XLEN
`define XLEN 32
`endif

module alu_arbiter #(
   parameter int N = `XLEN
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [N-1:0] req_a0,
   input  logic [N-1:0] req_b0,
   input  logic [N-1:0] req_a1,
   input  logic [N-1:0] req_b1,
   input  logic [3:0]   req_op0,
   input  logic [3:0]   req_op1,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_result,
   output logic         rsp_illegal
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_EQ   = 4'd5;
   localparam logic [3:0] ALU_NE   = 4'd6;
   localparam logic [3:0] ALU_SLT  = 4'd7;
   localparam logic [3:0] ALU_SLTU = 4'd8;
   localparam logic [3:0] ALU_SGE  = 4'd9;
   localparam logic [3:0] ALU_SGEU = 4'd10;

   logic [1:0]   grant;
   logic         prefer1;
   logic         can_accept;
   logic         fire;
   logic         sel;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic [3:0]   op_code;
   logic [N-1:0] alu_res;
   logic         alu_ill;

`ifdef ALU_ARB_RR_EN
   logic ptr;

   // Pointer names the preferred requester; it moves only when a transfer happens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (fire) begin
         ptr <= ~sel;
      end
   end

   assign prefer1 = ptr;
`else
   assign prefer1 = 1'b0;
`endif

   // Grant depends only on valids and priority, never on op codes or operands.
   always_comb begin
      grant = req_valid;
      if (req_valid == 2'b11) begin
         grant = prefer1 ? 2'b10 : 2'b01;
      end
   end

   assign can_accept = !rsp_valid || rsp_ready;
   assign req_ready  = grant & {2{can_accept}};
   assign fire       = |(req_valid & req_ready);
   assign sel        = grant[1];

   assign op_a    = sel ? req_a1  : req_a0;
   assign op_b    = sel ? req_b1  : req_b0;
   assign op_code = sel ? req_op1 : req_op0;

   // The single shared ALU; undefined codes yield zero with the illegal flag.
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (op_code)
         ALU_ADD:  alu_res = op_a + op_b;
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_AND:  alu_res = op_a & op_b;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_EQ:   alu_res = N'(op_a == op_b);
         ALU_NE:   alu_res = N'(op_a != op_b);
         ALU_SLT:  alu_res = N'($signed(op_a) < $signed(op_b));
         ALU_SLTU: alu_res = N'(op_a < op_b);
         ALU_SGE:  alu_res = N'($signed(op_a) >= $signed(op_b));
         ALU_SGEU: alu_res = N'(op_a >= op_b);
         default:  alu_ill = 1'b1;
      endcase
   end

   // Response buffer: reload on accept (no bubble), drain when consumed, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_result  <= '0;
         rsp_illegal <= 1'b0;
      end else if (fire) begin
         rsp_valid   <= 1'b1;
         rsp_id      <= sel;
         rsp_result  <= alu_res;
         rsp_illegal <= alu_ill;
      end else if (rsp_ready) begin
         rsp_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (vectors, corner sequences, random vs model)

module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [3:0]  req_op0, req_op1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_illegal;

   int checks = 0;
   int errors = 0;

   // reference model state: one pending response plus preferred requester
   logic        m_valid;
   logic        m_id;
   logic [31:0] m_res;
   logic        m_ill;
   logic        m_ptr;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ill;
   } vec_t;

   vec_t vecs[14];

   alu_arbiter #(.N(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a0      (req_a0),
      .req_b0      (req_b0),
      .req_a1      (req_a1),
      .req_b1      (req_b1),
      .req_op0     (req_op0),
      .req_op1     (req_op1),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .rsp_illegal (rsp_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic il);
      il = 1'b0;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = (a == b) ? 32'd1 : 32'd0;
         4'd6:  r = (a != b) ? 32'd1 : 32'd0;
         4'd7:  r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
         4'd8:  r = (a <  b) ? 32'd1 : 32'd0;
         4'd9:  r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         4'd10: r = (a >= b) ? 32'd1 : 32'd0;
         default: begin r = 32'd0; il = 1'b1; end
      endcase
   endfunction

   // One clock: check ready before the edge, advance model, check buffer after the edge.
   task automatic step();
      logic [1:0]  er;
      logic        w;
      logic [31:0] r;
      logic        il;
      #2;
      if (req_valid == 2'b11) w = RR ? m_ptr : 1'b0;
      else                    w = req_valid[1];
      er = ((req_valid != 2'b00) && (!m_valid || rsp_ready)) ? (w ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", {30'd0, req_ready}, {30'd0, er});
      @(posedge clk);
      if (er != 2'b00) begin
         if (w) ref_alu(req_op1, req_a1, req_b1, r, il);
         else   ref_alu(req_op0, req_a0, req_b0, r, il);
         m_valid = 1'b1;
         m_id    = w;
         m_res   = r;
         m_ill   = il;
         m_ptr   = ~w;
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
      #1;
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      if (m_valid) begin
         chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
         chk("rsp_result", rsp_result, m_res);
         chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, m_ill});
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_id    = 1'b0;
      m_res   = 32'd0;
      m_ill   = 1'b0;
      m_ptr   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
      chk({tag, "_rsp_result"}, rsp_result, 32'd0);
      chk({tag, "_rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drive(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (i == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
      else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      logic [31:0] s_res;
      logic        s_id;
      logic        s_ill;
      logic [1:0]  exp_ids [4];
      logic [31:0] a;
      logic [31:0] b;

      vecs[0]  = '{4'd0,  32'd5,          32'd7,          32'd12,          1'b0};
      vecs[1]  = '{4'd7,  32'hFFFF_FFFF,  32'd1,          32'd1,           1'b0};
      vecs[2]  = '{4'd8,  32'hFFFF_FFFF,  32'd1,          32'd0,           1'b0};
      vecs[3]  = '{4'd1,  32'd3,          32'd5,          32'hFFFF_FFFE,   1'b0};
      vecs[4]  = '{4'd2,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,   1'b0};
      vecs[5]  = '{4'd3,  32'hF000_0001,  32'h0000_0F00,  32'hF000_0F01,   1'b0};
      vecs[6]  = '{4'd4,  32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,   1'b0};
      vecs[7]  = '{4'd5,  32'h1234_5678,  32'h1234_5678,  32'd1,           1'b0};
      vecs[8]  = '{4'd6,  32'h1234_5678,  32'h1234_5678,  32'd0,           1'b0};
      vecs[9]  = '{4'd9,  32'd1,          32'hFFFF_FFFF,  32'd1,           1'b0};
      vecs[10] = '{4'd10, 32'd1,          32'hFFFF_FFFF,  32'd0,           1'b0};
      vecs[11] = '{4'd15, 32'd9,          32'd9,          32'd0,           1'b1};
      vecs[12] = '{4'd11, 32'd4,          32'd4,          32'd0,           1'b1};
      vecs[13] = '{4'd0,  32'hFFFF_FFFF,  32'd2,          32'd1,           1'b0};

      req_valid = 2'b00;
      rsp_ready = 1'b0;
      req_a0 = 32'd0; req_b0 = 32'd0; req_op0 = 4'd0;
      req_a1 = 32'd0; req_b1 = 32'd0; req_op1 = 4'd0;
      do_reset();

      // table vectors: requester 0 first (accept on first edge after reset), then alternate
      rsp_ready = 1'b1;
      for (int k = 0; k < 14; k++) begin
         int r;
         r = (k == 1 || k == 2) ? 1 : (k % 2);
         drive(r, vecs[k].op, vecs[k].a, vecs[k].b);
         req_valid = (r == 0) ? 2'b01 : 2'b10;
         step();
         chk($sformatf("vec%0d_result", k), rsp_result, vecs[k].res);
         chk($sformatf("vec%0d_illegal", k), {31'd0, rsp_illegal}, {31'd0, vecs[k].ill});
         chk($sformatf("vec%0d_id", k), {31'd0, rsp_id}, r[31:0]);
      end
      req_valid = 2'b00;
      step();

      // both requesters valid for four cycles from a fresh reset
      do_reset();
      exp_ids = RR ? '{2'd0, 2'd1, 2'd0, 2'd1} : '{2'd0, 2'd0, 2'd0, 2'd0};
      drive(0, 4'd0, 32'd1, 32'd2);
      drive(1, 4'd0, 32'd10, 32'd20);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("rr%0d_id", k), {31'd0, rsp_id}, {30'd0, exp_ids[k]});
      end

      // stall for three cycles, then drain and reload on the same edge
      do_reset();
      drive(0, 4'd0, 32'd100, 32'd23);
      req_valid = 2'b01;
      rsp_ready = 1'b1;
      step();
      s_res = rsp_result; s_id = rsp_id; s_ill = rsp_illegal;
      chk("stall_load", s_res, 32'd123);
      drive(0, 4'd0, 32'd1, 32'd1);
      drive(1, 4'd0, 32'd2, 32'd2);
      req_valid = 2'b11;
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_ready", {30'd0, req_ready}, 32'd0);
         chk("stall_result", rsp_result, 32'd123);
         chk("stall_id", {31'd0, rsp_id}, {31'd0, s_id});
         chk("stall_illegal", {31'd0, rsp_illegal}, {31'd0, s_ill});
      end
      rsp_ready = 1'b1;
      step();
      chk("reload_valid", {31'd0, rsp_valid}, 32'd1);
      chk("reload_result", rsp_result, RR ? 32'd4 : 32'd2);

      // asynchronous reset mid-cycle with a response pending
      req_valid = 2'b01;
      drive(0, 4'd2, 32'hFF, 32'h0F);
      step();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midrst");
      req_valid = 2'b00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      chk("post_rst_no_replay", {31'd0, rsp_valid}, 32'd0);
      req_valid = 2'b11;
      step();
      chk("post_rst_grant_id", {31'd0, rsp_id}, 32'd0);

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         for (int r = 0; r < 2; r++) begin
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            drive(r, 4'($urandom_range(0, 15)), a, b);
         end
         req_valid = 2'($urandom_range(0, 3));
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
